// File: rtl/fir_pkg.sv
// Shared FIR constants and types used by the delay chain, tap-group MAC and adder tree.
package fir_pkg;
    localparam int NTAP   = 10;
    localparam int DATA_W = 3;
    localparam int COEF_W = 16;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTAP);
    localparam int OUT_W  = 16;
    localparam int IDX_W  = $clog2(NTAP);

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        RUN,
        DONE
    } firState_t;

    typedef logic [IDX_W-1:0] tapIdx_t;
endpackage

// File: rtl/fir_coef_bank.sv
// NTAP x COEF_W coefficient register file: gated write port, combinational read.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int NTAP   = fir_pkg::NTAP,
    parameter int COEF_W = fir_pkg::COEF_W
) (
    input  logic                     iClk12M,
    input  logic                     iRst,
    input  logic                     iWrEn,
    input  tapIdx_t                  iWrAddr,
    input  logic signed [COEF_W-1:0] iWrData,
    input  tapIdx_t                  iRdAddr,
    output logic signed [COEF_W-1:0] oRdData
);

    logic signed [COEF_W-1:0] coefReg [NTAP];

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            for (int k = 0; k < NTAP; k++) begin
                coefReg[k] <= '0;
            end
        end else if (iWrEn) begin
            coefReg[iWrAddr] <= iWrData;
        end
    end

    assign oRdData = coefReg[iRdAddr];

endmodule

// File: rtl/fir_tap_mac.sv
// Time-multiplexed MAC over one 10-tap group: one multiply per clock, result 12 clocks after the strobe.
// Define FIR_MAC_SAT_EN to saturate the result to OUT_W bits before it lands on oMac.
module fir_tap_mac
    import fir_pkg::*;
#(
    parameter int NTAP   = fir_pkg::NTAP,
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int COEF_W = fir_pkg::COEF_W,
    parameter int ACC_W  = fir_pkg::ACC_W,
    parameter int OUT_W  = fir_pkg::OUT_W
) (
    input  logic                     iClk12M,
    input  logic                     iRst,
    input  logic                     iEnSample600k,
    input  logic [NTAP*DATA_W-1:0]   iDelay,
    input  logic                     iCoefWr,
    input  tapIdx_t                  iCoefAddr,
    input  logic signed [COEF_W-1:0] iCoefData,
    output logic signed [ACC_W-1:0]  oMac,
    output logic                     oMacValid,
    output logic                     oBusy,
    output logic                     oOverrun
);

    localparam int      PROD_W   = DATA_W + COEF_W;
    localparam tapIdx_t LAST_IDX = tapIdx_t'(NTAP - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 <<< (OUT_W - 1)));

    firState_t                state;
    tapIdx_t                  idx;
    logic [NTAP*DATA_W-1:0]   delaySnap;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] tap;
    logic signed [COEF_W-1:0] coef;
    logic                     coefWrEn;

    function automatic logic signed [PROD_W-1:0] mulFull(
        input logic signed [DATA_W-1:0] a,
        input logic signed [COEF_W-1:0] b
    );
        logic signed [PROD_W-1:0] aExt;
        logic signed [PROD_W-1:0] bExt;
        aExt = {{COEF_W{a[DATA_W-1]}}, a};
        bExt = {{DATA_W{b[COEF_W-1]}}, b};
        return aExt * bExt;
    endfunction

    function automatic logic signed [ACC_W-1:0] sextProd(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

    function automatic logic signed [ACC_W-1:0] satOut(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX) begin
            return SAT_MAX;
        end else if (a < SAT_MIN) begin
            return SAT_MIN;
        end
        return a;
    endfunction

    // Coefficients are frozen for the whole run, so the bank is only writable in IDLE.
    assign coefWrEn = iCoefWr && (state == IDLE) && (iCoefAddr <= LAST_IDX);
    assign tap      = delaySnap[idx*DATA_W +: DATA_W];

    fir_coef_bank #(
        .NTAP   (NTAP),
        .COEF_W (COEF_W)
    ) uCoefBank (
        .iClk12M (iClk12M),
        .iRst    (iRst),
        .iWrEn   (coefWrEn),
        .iWrAddr (iCoefAddr),
        .iWrData (iCoefData),
        .iRdAddr (idx),
        .oRdData (coef)
    );

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            delaySnap <= '0;
            oMac      <= '0;
            oMacValid <= 1'b0;
            oBusy     <= 1'b0;
            oOverrun  <= 1'b0;
        end else begin
            oMacValid <= 1'b0;
            if (iEnSample600k && (state != IDLE)) begin
                oOverrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (iEnSample600k) begin
                        state <= LATCH;
                        oBusy <= 1'b1;
                    end
                end
                // Chain shifted on the strobe edge, so this snapshot already holds the new sample.
                LATCH: begin
                    delaySnap <= iDelay;
                    acc       <= '0;
                    idx       <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    acc <= acc + sextProd(mulFull(tap, coef));
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
`ifdef FIR_MAC_SAT_EN
                    oMac <= satOut(acc);
`else
                    oMac <= acc;
`endif
                    oMacValid <= 1'b1;
                    oBusy     <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
